seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse operation of the team's 4x4 combinational array multiplier.
- Takes a DW-bit dividend and a VW-bit divisor.
- Produces a DW-bit quotient and a VW-bit remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so it can sit behind the datapath that feeds the multiplier, or check the multiplier's results.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW <= DW).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  DW  unsigned numerator; captured on accepted start.
- divisor  input  VW  unsigned denominator; captured on accepted start.
- ready  output  1  block can accept start (state != CALC).
- busy  output  1  division in progress (state == CALC).
- done  output  1  single-cycle pulse: results valid.
- quotient  output  DW  result quotient; held until next accepted start.
- remainder  output  VW  result remainder; held until next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, ready=1, busy=0, done=0.
  - quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset mid-CALC aborts the division; no done is produced.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: one cycle, done=1.
- Acceptance: start=1 while state is IDLE or DONE, at edge T.
  - Capture the operands.
  - Clear the partial remainder P (VW+1 bits) and the working quotient register Q (DW bits) to 0.
  - Load the counter with DW-1.
  - If divisor==0, go directly to DONE instead (see below). Otherwise go to CALC.
- CALC, one iteration per cycle:
  - P' = {P[VW-1:0], dividend_reg MSB}.
  - Shift dividend_reg left by one.
  - D = P' - {1'b0, divisor_reg}, computed VW+2 bits wide.
  - If D is non-negative: P=D[VW:0] and shift 1 into Q LSB. Otherwise: P=P' and shift 0 into Q LSB.
  - Counter decrements each cycle. When the counter is 0 in CALC, go to DONE.
  - Start is ignored in CALC.
- Latency: start accepted at edge T → CALC occupies cycles T+1..T+DW → done=1 during cycle T+DW+1.
  - Total DW+1 cycles from acceptance to the done cycle (9 for DW=8).
- On entry to DONE: quotient=Q, remainder=P[VW-1:0], div_by_zero=0.
- Divide by zero:
  - Skip CALC; DONE follows acceptance by one cycle.
  - quotient = all ones, remainder = all ones, div_by_zero=1.
- DONE to next state:
  - Unconditionally returns to IDLE, unless start=1 in that cycle. Then the new operation is accepted back-to-back and the next state is CALC (or DONE for a zero divisor).
  - Previous results remain on the outputs until that next acceptance edge.
- Output hold: quotient, remainder and div_by_zero change only on entry to DONE or on reset.
- Arithmetic: fully unsigned. The maximum quotient, 2^DW-1, occurs for divisor=1. The remainder is always < divisor.
- Operands are registered on acceptance. Changes on the dividend and divisor inputs during CALC have no effect.

Decomposition:
- Shared package `div_pkg`:
  - State enum {IDLE, CALC, DONE}.
  - Default widths DW=8, VW=4.
  - Counter width constant $clog2(DW).
- One natural combinational sub-module: `div_step`.
  - Inputs: P, next dividend bit, divisor.
  - Outputs: new P, quotient bit.
  - Instantiated once. The FSM/counter/registers stay in the top level.

Test Plan:
- Reset then idle: after rst, check ready=1, busy=0, done=0, quotient=0, remainder=0. Then assert rst for 2 cycles mid-CALC (dividend=200, divisor=7): no done pulse, outputs 0.
- Basic: dividend=200, divisor=7 → done exactly 9 cycles after the accepting edge, quotient=28, remainder=4, div_by_zero=0. busy=1 for 8 cycles.
- Boundaries:
  - 255/15 → q=17, r=0.
  - 255/1 → q=255, r=0.
  - 13/15 → q=0, r=13.
  - 0/5 → q=0, r=0.
- Divide by zero: 200/0 → done 1 cycle after acceptance, q=8'hFF, r=4'hF, div_by_zero=1. A following 100/3 → q=33, r=1, div_by_zero=0.
- Handshake:
  - start pulsed during busy with other operands is ignored; the result matches the original operation.
  - start held high in the DONE cycle launches back-to-back 77/9 → q=8, r=5 with no IDLE gap. The previous results stay stable until the acceptance edge.
- Exhaustive/random: all 256x15 non-zero combinations checked against reference q=a/b, r=a%b, with output stability verified between done pulses.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// The state encoding and counter sizing are kept here so the top level and bench agree.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;
    localparam int DEF_CW = $clog2(DEF_DW);

    // A one-bit dividend would give a zero-width counter, so clamp to at least one bit.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle between an operand source and the divider.
// The master drives operands and start; the slave returns status and results.
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   p_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   p_o,
    output logic          q_bit_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;

    // P stays below the divisor, so its top bit is always zero; carrying it keeps the
    // trial subtraction one bit wider than P' so the sign lands in diff[VW+1].
    assign shifted = {p_i, bit_i};
    assign diff    = shifted - {2'b00, divisor_i};
    assign q_bit_o = ~diff[VW+1];
    assign p_o     = q_bit_o ? diff[VW:0] : shifted[VW:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with results held until the next operation completes.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);

    localparam int CW = cnt_width(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   p_q, p_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   step_p;
    logic          step_q;

    div_step #(
        .VW(VW)
    ) u_step (
        .p_i       (p_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .p_o       (step_p),
        .q_bit_o   (step_q)
    );

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        q_d     = q_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    p_d   = '0;
                    q_d   = '0;
                    cnt_d = CW'(DW - 1);
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                p_d   = step_p;
                q_d   = {q_q[DW-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                // The last iteration's bit goes straight into the result register.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = {q_q[DW-2:0], step_q};
                    rem_d   = step_p[VW-1:0];
                    dbz_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and all state uses non-blocking assignment so
        // every register samples the pre-edge values computed above.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            q_q     <= q_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.ready       = (state_q != CALC);
    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: expected results are queued at launch
// and popped on each done pulse; result outputs must not move between pulses.
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] held_q   = '0;
    logic [VW-1:0] held_r   = '0;
    logic          held_dbz = 1'b0;

    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = '1;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / DW'(b);
            e.r   = VW'(a % DW'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL launch_ready: %0d/%0d ready=%b required 1", a, b, bus.ready);
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // lat is the cycle index of the done cycle, counting the accepting cycle as 0.
    task automatic run_to_done(output int lat, output int busy_n);
        bit   got;
        int   e;
        exp_t x;
        got    = 1'b0;
        e      = 0;
        busy_n = 0;
        while (!got && e < 64) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: q=%0d r=%0d with empty scoreboard",
                             bus.quotient, bus.remainder);
                end else begin
                    x = sb.pop_front();
                    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {x.q, x.r, x.dbz}) begin
                        errors++;
                        $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                                 x.a, x.b, bus.quotient, bus.remainder, bus.div_by_zero,
                                 x.q, x.r, x.dbz);
                    end
                    held_q   = x.q;
                    held_r   = x.r;
                    held_dbz = x.dbz;
                end
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                checks++;
                if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {held_q, held_r, held_dbz}) begin
                    errors++;
                    $display("FAIL hold: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                             bus.quotient, bus.remainder, bus.div_by_zero, held_q, held_r, held_dbz);
                end
                @(posedge clk);
                #1;
                e++;
            end
        end
        lat = e + 1;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !==
                {1'b0, held_q, held_r, held_dbz}) begin
                errors++;
                $display("FAIL idle_hold: got done=%b q=%0d r=%0d dbz=%b required done=0 q=%0d r=%0d dbz=%b",
                         bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                         held_q, held_r, held_dbz);
            end
        end
    endtask

    task automatic test_reset();
        bit saw_done;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status: got ready/busy/done=%b required 100",
                     {bus.ready, bus.busy, bus.done});
        end
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_results: got q=%0d r=%0d dbz=%b required 0 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;

        launch(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_done: got a done pulse after mid-CALC reset, required none");
        end
        checks++;
        if ({bus.ready, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero} !==
            {1'b1, 1'b0, {DW{1'b0}}, {VW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL abort_state: got ready=%b busy=%b q=%0d r=%0d dbz=%b required 1 0 0 0 0",
                     bus.ready, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        launch(8'd200, 4'd7);
        run_to_done(lat, bn);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 9", lat);
        end
        checks++;
        if (bn != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 8", bn);
        end
        idle_cycles(2);
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] a_tab [4] = '{8'd255, 8'd255, 8'd13, 8'd0};
        logic [VW-1:0] b_tab [4] = '{4'd15, 4'd1, 4'd15, 4'd5};
        int lat, bn;
        for (int i = 0; i < 4; i++) begin
            launch(a_tab[i], b_tab[i]);
            run_to_done(lat, bn);
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL boundary_latency %0d/%0d: got %0d required 9", a_tab[i], b_tab[i], lat);
            end
            idle_cycles(1);
        end
    endtask

    task automatic test_div_zero();
        int lat, bn;
        launch(8'd200, 4'd0);
        run_to_done(lat, bn);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d required 1", lat);
        end
        idle_cycles(1);
        launch(8'd100, 4'd3);
        run_to_done(lat, bn);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL after_dbz_latency: got %0d required 9", lat);
        end
        idle_cycles(1);
    endtask

    task automatic test_ignore_start();
        int lat, bn;
        launch(8'd200, 4'd7);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd3;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got ready=%b during CALC required 0", bus.ready);
        end
        bus.start = 1'b0;
        run_to_done(lat, bn);
        checks++;
        if (lat + 1 != 9) begin
            errors++;
            $display("FAIL ignore_latency: got %0d required 9", lat + 1);
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        launch(8'd100, 4'd3);
        run_to_done(lat, bn);
        launch(8'd77, 4'd9);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: got busy=%b after accepting in DONE required 1", bus.busy);
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== {8'd33, 4'd1}) begin
            errors++;
            $display("FAIL b2b_prev_held: got q=%0d r=%0d required q=33 r=1",
                     bus.quotient, bus.remainder);
        end
        run_to_done(lat, bn);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL b2b_latency: got %0d required 9", lat);
        end
        idle_cycles(1);
    endtask

    task automatic test_exhaustive();
        int lat, bn;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(DW'(a), VW'(b));
                run_to_done(lat, bn);
                checks++;
                if (lat != 9) begin
                    errors++;
                    $display("FAIL sweep_latency %0d/%0d: got %0d required 9", a, b, lat);
                end
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_exhaustive();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
